rvx_dm_bridge: RTL and testbench



---
 rtl/rvx_dm_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_rvx_dm_bridge.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvx_dm_bridge.sv
// rvx_dm_bridge: CPU data-port bridge. It passes ordinary accesses to DataMem and
// decodes a 4 KiB MMIO window that holds a paced TX console FIFO and a halt register.
// The firmware uses the FIFO to print bytes and the halt register to end the run.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   dmAddrIn/dmWeIn/dmReIn       CPU request: byte address, write and read strobes
//   dmDataWIn/dmWDataIn          CPU byte enables and write data
//   dmRDataOut                   read data, valid the cycle after dmReIn (0 otherwise)
//   mem*Out / memRDataIn         DataMem request (combinational mirror) and its read data
//   conValidOut/conDataOut       console byte stream towards the sink
//   conReadyIn                   console sink ready
//   haltOut/haltCodeOut          sticky halt flag and exit code
module rvx_dm_bridge #(
    parameter int unsigned BUS_W      = 32,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DRAIN_DIV  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] dmAddrIn,
    input  logic             dmWeIn,
    input  logic             dmReIn,
    input  logic [3:0]       dmDataWIn,
    input  logic [BUS_W-1:0] dmWDataIn,
    output logic [BUS_W-1:0] dmRDataOut,
    output logic [BUS_W-1:0] memAddrOut,
    output logic             memWeOut,
    output logic             memReOut,
    output logic [3:0]       memDataWOut,
    output logic [BUS_W-1:0] memWDataOut,
    input  logic [BUS_W-1:0] memRDataIn,
    output logic             conValidOut,
    output logic [7:0]       conDataOut,
    input  logic             conReadyIn,
    output logic             haltOut,
    output logic [7:0]       haltCodeOut
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned GAP_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

    localparam logic [11:0] OFF_TXDATA = 12'h000;
    localparam logic [11:0] OFF_STATUS = 12'h004;
    localparam logic [11:0] OFF_HALT   = 12'h008;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic             isMmio;
    logic [11:0]      offset;
    logic             pushReq, pushAccept, pop, full, empty;
    logic             statusWr, haltWr;
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] count, countNext;
    logic             overflow;
    state_t           state, stateNext;
    logic [GAP_W-1:0] gapCnt, gapCntNext;
    logic             rdValid, selMmio;
    logic [BUS_W-1:0] mmioRData, mmioRDataReg;

    // Address decode and request mirror; MMIO accesses never strobe DataMem.
    assign isMmio      = (dmAddrIn[31:12] == MMIO_BASE[31:12]);
    assign offset      = dmAddrIn[11:0];
    assign memAddrOut  = dmAddrIn;
    assign memWDataOut = dmWDataIn;
    assign memDataWOut = dmDataWIn;
    assign memWeOut    = dmWeIn && !isMmio;
    assign memReOut    = dmReIn && !isMmio;

    assign pushReq  = isMmio && dmWeIn && (offset == OFF_TXDATA) && dmDataWIn[0];
    assign statusWr = isMmio && dmWeIn && (offset == OFF_STATUS);
    assign haltWr   = isMmio && dmWeIn && (offset == OFF_HALT) && dmDataWIn[0];

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    // SEND is only entered with data queued, so a beat always has a head byte.
    assign pop        = (state == SEND) && conReadyIn;
    assign pushAccept = pushReq && (!full || pop);

    // FIFO occupancy after this edge.
    always_comb begin
        countNext = count;
        if (pushAccept && !pop) begin
            countNext = count + CNT_W'(1);
        end else if (!pushAccept && pop) begin
            countNext = count - CNT_W'(1);
        end
    end

    // FIFO storage is not reset; conDataOut is gated by SEND so stale entries never show.
    always_ff @(posedge clk) begin
        if (pushAccept) begin
            fifoMem[wrPtr] <= dmWDataIn[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pushAccept) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)        rdPtr <= rdPtr + PTR_W'(1);
            count <= countNext;
            if (statusWr) begin
                overflow <= 1'b0;
            end else if (pushReq && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gapCnt <= '0;
        end else begin
            state  <= stateNext;
            gapCnt <= gapCntNext;
        end
    end

    // Drain FSM next state. The gap leaves GAP on the cycle its count would reach 0,
    // which spaces beats exactly DRAIN_DIV cycles apart under continuous ready.
    always_comb begin
        stateNext  = state;
        gapCntNext = gapCnt;
        unique case (state)
            IDLE: begin
                if (!empty) stateNext = SEND;
            end
            SEND: begin
                if (conReadyIn) begin
                    if (DRAIN_DIV == 1) begin
                        stateNext = (countNext != '0) ? SEND : IDLE;
                    end else begin
                        stateNext  = GAP;
                        gapCntNext = GAP_W'(DRAIN_DIV - 1);
                    end
                end
            end
            GAP: begin
                if (gapCnt <= GAP_W'(1)) begin
                    gapCntNext = '0;
                    stateNext  = empty ? IDLE : SEND;
                end else begin
                    gapCntNext = gapCnt - GAP_W'(1);
                end
            end
            default: begin
                stateNext  = IDLE;
                gapCntNext = '0;
            end
        endcase
    end

    assign conValidOut = (state == SEND);
    assign conDataOut  = conValidOut ? fifoMem[rdPtr] : 8'h00;

    // MMIO read value from register state at the read edge.
    always_comb begin
        mmioRData = '0;
        if (offset == OFF_STATUS) begin
            mmioRData = BUS_W'({8'(count), 5'b0, overflow, empty, full});
        end
    end

    // Read-path select, captured on the read edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdValid      <= 1'b0;
            selMmio      <= 1'b0;
            mmioRDataReg <= '0;
        end else begin
            rdValid      <= dmReIn;
            selMmio      <= dmReIn && isMmio;
            mmioRDataReg <= dmReIn ? mmioRData : '0;
        end
    end

    assign dmRDataOut = !rdValid ? '0 : (selMmio ? mmioRDataReg : memRDataIn);

    // Halt is sticky: only the first HALT write after reset takes effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haltOut     <= 1'b0;
            haltCodeOut <= 8'h00;
        end else if (haltWr && !haltOut) begin
            haltOut     <= 1'b1;
            haltCodeOut <= dmWDataIn[7:0];
        end
    end

endmodule

// File: tb/tb_rvx_dm_bridge.sv
// Bench for rvx_dm_bridge: decode vector table, directed console/halt/DataMem
// sequences, and a randomized run against a queue-based model of the bridge.
module tb_rvx_dm_bridge;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DIV   = 4;
    localparam logic [31:0] TXDATA = 32'h1000_0000;
    localparam logic [31:0] STATUS = 32'h1000_0004;
    localparam logic [31:0] HALT   = 32'h1000_0008;

    logic        clk, rst;
    logic [31:0] dmAddr, dmWData, dmRData, memAddr, memWData;
    logic        dmWe, dmRe, memWe, memRe;
    logic [3:0]  dmDataW, memDataW;
    bit   [31:0] memRData;
    logic        conValid, conReady, halt;
    logic [7:0]  conData, haltCode;

    int errors = 0;
    int checks = 0;

    rvx_dm_bridge #(
        .BUS_W(32), .MMIO_BASE(32'h1000_0000), .FIFO_DEPTH(DEPTH), .DRAIN_DIV(DIV)
    ) dut (
        .clk(clk), .rst(rst),
        .dmAddrIn(dmAddr), .dmWeIn(dmWe), .dmReIn(dmRe), .dmDataWIn(dmDataW),
        .dmWDataIn(dmWData), .dmRDataOut(dmRData),
        .memAddrOut(memAddr), .memWeOut(memWe), .memReOut(memRe),
        .memDataWOut(memDataW), .memWDataOut(memWData), .memRDataIn(memRData),
        .conValidOut(conValid), .conDataOut(conData), .conReadyIn(conReady),
        .haltOut(halt), .haltCodeOut(haltCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple DataMem: 256 words, synchronous read with one-cycle latency.
    bit [31:0] dataMem [256];
    always @(posedge clk) begin
        if (memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (memDataW[b]) dataMem[memAddr[9:2]][8*b +: 8] <= memWData[8*b +: 8];
            end
        end
        if (memRe) memRData <= dataMem[memAddr[9:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic busIdle;
        dmAddr = '0; dmWe = 1'b0; dmRe = 1'b0; dmDataW = '0; dmWData = '0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        dmAddr = addr; dmWData = data; dmDataW = be; dmWe = 1'b1;
        tick;
        busIdle;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        dmAddr = addr; dmRe = 1'b1;
        tick;
        busIdle;
        data = dmRData;
    endtask

    task automatic resetDut;
        busIdle;
        conReady = 1'b0;
        rst = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        tick;
    endtask

    // Decode vectors: request in, expected DataMem strobes out.
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        re;
        logic [3:0]  be;
        logic        expMemWe;
        logic        expMemRe;
    } vec_t;

    vec_t vecs [8];

    // Random-run model state.
    logic [7:0]  mq [$];
    logic        mOvf, mHalt;
    logic [7:0]  mCode;
    bit   [31:0] shadow [256];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] r;
        logic [7:0]  gotData [$];
        int          gotCyc [$];

        rst = 1'b1;
        conReady = 1'b0;
        busIdle;

        vecs[0] = '{32'h0000_0100, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0200, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1};
        vecs[2] = '{32'h1000_0004, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0};
        vecs[3] = '{32'h1000_000C, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0};
        vecs[4] = '{32'h1000_0FFC, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0};
        vecs[5] = '{32'h1000_1000, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0};
        vecs[6] = '{32'h0FFF_FFFC, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1};
        vecs[7] = '{32'h1000_0000, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0};

        // Reset state (asserted)
        tick;
        chk("reset_valid", 32'(conValid), 32'd0);
        chk("reset_data", 32'(conData), 32'd0);
        chk("reset_halt", {23'd0, halt, haltCode}, 32'd0);
        chk("reset_rdata", dmRData, 32'd0);
        resetDut;

        for (int i = 0; i < 8; i++) begin
            dmAddr = vecs[i].addr; dmWe = vecs[i].we; dmRe = vecs[i].re;
            dmDataW = vecs[i].be; dmWData = 32'hA5A5_0000 + 32'(i);
            #1;
            chk($sformatf("vec%0d_strobes", i), {30'd0, memWe, memRe},
                {30'd0, vecs[i].expMemWe, vecs[i].expMemRe});
            chk($sformatf("vec%0d_addr", i), memAddr, vecs[i].addr);
            chk($sformatf("vec%0d_be", i), 32'(memDataW), 32'(vecs[i].be));
            tick;
            busIdle;
        end
        resetDut;

        // Single byte: push -> valid two edges later for one cycle
        conReady = 1'b1;
        wr(TXDATA, 32'h41, 4'h1);
        chk("t1_valid_edge1", 32'(conValid), 32'd0);
        tick;
        chk("t1_valid_edge2", 32'(conValid), 32'd1);
        chk("t1_data", 32'(conData), 32'h41);
        tick;
        chk("t1_valid_after_beat", 32'(conValid), 32'd0);
        rd(STATUS, r);
        chk("t1_status", r, 32'h0000_0002);

        // Overflow and paced drain
        conReady = 1'b0;
        repeat (6) tick;
        for (int i = 0; i < 10; i++) wr(TXDATA, 32'h30 + 32'(i), 4'h1);
        rd(STATUS, r);
        chk("t2_status_full", r, 32'h0000_0805);
        conReady = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (conValid) begin
                gotData.push_back(conData);
                gotCyc.push_back(k);
            end
            tick;
        end
        chk("t2_beats", 32'(gotData.size()), 32'd8);
        for (int i = 0; i < gotData.size() && i < 8; i++) begin
            chk($sformatf("t2_byte%0d", i), 32'(gotData[i]), 32'h30 + 32'(i));
            if (i > 0) chk($sformatf("t2_gap%0d", i), 32'(gotCyc[i] - gotCyc[i-1]), 32'(DIV));
        end
        rd(STATUS, r);
        chk("t2_status_drained", r, 32'h0000_0006);
        wr(STATUS, 32'h0, 4'hF);
        rd(STATUS, r);
        chk("t2_status_ovf_clear", r, 32'h0000_0002);

        // Backpressure: data stable while ready is low
        conReady = 1'b0;
        wr(TXDATA, 32'h77, 4'h1);
        tick;
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", 32'(conValid), 32'd1);
            chk("t3_hold_data", 32'(conData), 32'h77);
            tick;
        end
        rd(STATUS, r);
        chk("t3_status_still_queued", r, 32'h0000_0100);
        conReady = 1'b1;
        tick;
        chk("t3_valid_after_pop", 32'(conValid), 32'd0);
        rd(STATUS, r);
        chk("t3_status_empty", r, 32'h0000_0002);

        // DataMem pass-through
        dmAddr = 32'h0000_0100; dmWData = 32'hDEAD_BEEF; dmDataW = 4'hF; dmWe = 1'b1;
        #1;
        chk("t4_memwe_on", 32'(memWe), 32'd1);
        tick;
        busIdle;
        #1;
        chk("t4_memwe_off", 32'(memWe), 32'd0);
        dmAddr = 32'h0000_0100; dmRe = 1'b1;
        #1;
        chk("t4_memre_on", 32'(memRe), 32'd1);
        tick;
        busIdle;
        chk("t4_rdata", dmRData, 32'hDEAD_BEEF);
        tick;
        chk("t4_rdata_idle", dmRData, 32'd0);
        dmAddr = 32'h1000_000C; dmWData = 32'h1234_5678; dmDataW = 4'hF; dmWe = 1'b1;
        #1;
        chk("t4_mmio_no_memwe", 32'(memWe), 32'd0);
        tick;
        busIdle;

        // Halt: first write wins
        dmAddr = HALT; dmWData = 32'h2A; dmDataW = 4'h1; dmWe = 1'b1;
        #1;
        chk("t5_halt_before_edge", 32'(halt), 32'd0);
        tick;
        busIdle;
        chk("t5_halt_set", {23'd0, halt, haltCode}, {23'd0, 1'b1, 8'h2A});
        wr(HALT, 32'h55, 4'h1);
        repeat (3) tick;
        chk("t5_halt_held", {23'd0, halt, haltCode}, {23'd0, 1'b1, 8'h2A});

        // Reset mid-beat drops queued bytes
        conReady = 1'b0;
        wr(TXDATA, 32'h61, 4'h1);
        wr(TXDATA, 32'h62, 4'h1);
        wr(TXDATA, 32'h63, 4'h1);
        tick;
        chk("t6_valid_before_rst", 32'(conValid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid_async_rst", 32'(conValid), 32'd0);
        chk("t6_halt_async_rst", {23'd0, halt, haltCode}, 32'd0);
        tick;
        rst = 1'b0;
        tick;
        rd(STATUS, r);
        chk("t6_status_empty", r, 32'h0000_0002);
        chk("t6_valid_idle", 32'(conValid), 32'd0);

        // Randomized run against the queue model
        resetDut;
        begin
            logic        pendRd;
            logic [31:0] pendVal, status;
            logic        isM, beat, fullBefore;
            logic [11:0] off;
            int          lastBeat, op;
            logic [31:0] others [4];
            others[0] = 32'h1000_0000; others[1] = 32'h1000_0008;
            others[2] = 32'h1000_000C; others[3] = 32'h1000_07F0;
            for (int i = 0; i < 256; i++) shadow[i] = dataMem[i];
            mq.delete();
            mOvf = 1'b0; mHalt = 1'b0; mCode = 8'h00;
            pendRd = 1'b0; pendVal = '0; lastBeat = -100;

            for (int cyc = 0; cyc < 3000; cyc++) begin
                chk("rnd_rdata", dmRData, pendRd ? pendVal : 32'd0);
                chk("rnd_halt", {23'd0, halt, haltCode}, {23'd0, mHalt, mCode});

                busIdle;
                conReady = ($urandom_range(0, 2) != 0);
                op = int'($urandom_range(0, 19));
                if (op < 8) begin
                    dmAddr = TXDATA; dmWe = 1'b1; dmWData = $urandom;
                    dmDataW = 4'($urandom) | ((op < 6) ? 4'h1 : 4'h0);
                end else if (op < 11) begin
                    dmAddr = STATUS; dmRe = 1'b1;
                end else if (op == 11) begin
                    dmAddr = STATUS; dmWe = 1'b1; dmDataW = 4'($urandom);
                end else if (op == 12) begin
                    dmAddr = HALT; dmWe = 1'b1; dmWData = $urandom; dmDataW = 4'($urandom);
                end else if (op == 13) begin
                    dmAddr = others[$urandom_range(0, 3)]; dmRe = 1'b1;
                end else if (op < 17) begin
                    dmAddr = {22'd0, 8'($urandom), 2'b00}; dmWe = 1'b1;
                    dmWData = $urandom; dmDataW = 4'($urandom);
                end else if (op < 19) begin
                    dmAddr = {22'd0, 8'($urandom), 2'b00}; dmRe = 1'b1;
                end
                #1;

                isM = (dmAddr[31:12] == 20'h10000);
                off = dmAddr[11:0];
                chk("rnd_memreq", {memAddr[29:0], memWe, memRe},
                    {dmAddr[29:0], dmWe && !isM, dmRe && !isM});

                beat = conValid && conReady;
                if (conValid) begin
                    chk("rnd_valid_nonempty", 32'(mq.size() != 0), 32'd1);
                    if (mq.size() != 0) chk("rnd_condata", 32'(conData), 32'(mq[0]));
                end
                if (beat) begin
                    chk("rnd_spacing", 32'(cyc - lastBeat >= int'(DIV)), 32'd1);
                    lastBeat = cyc;
                end

                fullBefore = (mq.size() == int'(DEPTH));
                status = {16'd0, 8'(mq.size()), 5'd0, mOvf, mq.size() == 0, fullBefore};
                pendRd = dmRe;
                pendVal = !isM ? shadow[dmAddr[9:2]] : ((off == 12'h004) ? status : 32'd0);

                if (beat && mq.size() != 0) void'(mq.pop_front());
                if (isM && dmWe && off == 12'h000 && dmDataW[0]) begin
                    if (!fullBefore || beat) mq.push_back(dmWData[7:0]);
                    else mOvf = 1'b1;
                end
                if (isM && dmWe && off == 12'h004) mOvf = 1'b0;
                if (isM && dmWe && off == 12'h008 && dmDataW[0] && !mHalt) begin
                    mHalt = 1'b1;
                    mCode = dmWData[7:0];
                end
                if (!isM && dmWe) begin
                    for (int b = 0; b < 4; b++) begin
                        if (dmDataW[b]) shadow[dmAddr[9:2]][8*b +: 8] = dmWData[8*b +: 8];
                    end
                end
                @(posedge clk);
                #1;
            end

            chk("rnd_final_rdata", dmRData, pendRd ? pendVal : 32'd0);
            busIdle;
            conReady = 1'b1;
            for (int k = 0; k < 200 && mq.size() != 0; k++) begin
                #1;
                if (conValid) begin
                    chk("drain_data", 32'(conData), 32'(mq[0]));
                    void'(mq.pop_front());
                end
                tick;
            end
            chk("drain_empty", 32'(mq.size()), 32'd0);
            rd(STATUS, r);
            chk("drain_status", r, {29'd0, mOvf, 2'b10});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
